fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Dual-issue instruction queue between the fetch stage and the two instruction decoders of the superscalar front end.
- Each cycle it accepts 0-2 fetched instructions with their PCs.
- It presents the two oldest entries, in program order, to decoder slots 0 and 1, and retires 0-2 of them on the decoders' pop request.
- It absorbs fetch/decode rate mismatch, and flushes on branch/jump redirect (BEQ, JAL, JLR resolution).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- IW, 16, instruction width.
- PCW, 16, PC width.
- NOP_INSTR, 16'hF000, bubble word (opcode 1111 decodes to no writeback, no memory access).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  redirect: discard all entries
- push_cnt  in  2  number of instructions offered this cycle (0, 1 or 2; 3 is illegal)
- in_instr0  in  IW  older fetched instruction
- in_pc0  in  PCW  PC of in_instr0
- in_instr1  in  IW  younger fetched instruction (in_pc0+1)
- in_pc1  in  PCW  PC of in_instr1
- in_ready  out  1  queue can accept 2 this cycle
- pop_cnt  in  2  number of entries the decoders consume this cycle (0-2)
- out_valid0  out  1  slot 0 holds a real instruction
- out_instr0  out  IW  oldest entry, or NOP_INSTR
- out_pc0  out  PCW  PC of the oldest entry, or 0
- out_valid1  out  1  slot 1 holds a real instruction
- out_instr1  out  IW  second-oldest entry, or NOP_INSTR
- out_pc1  out  PCW  PC of the second-oldest entry, or 0
- occupancy  out  clog2(DEPTH+1)  current entry count

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - head=0, tail=0, occupancy=0, in_ready=1.
  - out_valid0/1=0, out_instr0/1=NOP_INSTR, out_pc0/1=0.
- Storage:
  - Circular buffer of {instr, pc}, with head (oldest) and tail (next free) pointers of clog2(DEPTH) bits.
  - Both pointers wrap modulo DEPTH.
  - A push of 2 writes tail and tail+1; wrap across index DEPTH-1 to 0 within one push is legal.
- in_ready:
  - in_ready = (DEPTH - occupancy) >= 2, computed from registered state only (no combinational path from pop_cnt).
  - Push accepted: eff_push = in_ready ? push_cnt : 0. A push offered while in_ready=0 is dropped; fetch must hold its PC.
- Outputs:
  - Combinational from registered state: out_valid0 = occupancy>=1, out_valid1 = occupancy>=2.
  - Entries are shown at head and head+1 (mod DEPTH).
  - An invalid slot drives NOP_INSTR and pc 0.
- Pop:
  - eff_pop = min(pop_cnt, occupancy), so a pop beyond occupancy is clamped and never underflows.
  - pop_cnt=2 with out_valid1=0 retires 1.
- Latency:
  - An instruction pushed in cycle N appears at the outputs in cycle N+1, and no earlier.
  - No same-cycle bypass from input to output.
- Update per rising edge, when flush=0:
  - head += eff_pop
  - tail += eff_push
  - occupancy = occupancy + eff_push - eff_pop
- Simultaneous push and pop are legal.
  - Full queue with pop 2 and push 2 in the same cycle: the push is refused, because in_ready was 0 at cycle start.
- Flush:
  - Highest priority. On the next edge head=tail=0 and occupancy=0.
  - The same-cycle push and pop are ignored.
  - The next cycle shows out_valid0/1=0 and in_ready=1.
- Program order:
  - in_instr0 is always older than in_instr1.
  - push_cnt=1 uses in_instr0 only.
- Illegal push_cnt=3 is treated as 2. A simulation assertion flags it.
- Reset asserted mid-operation clears all state immediately (asynchronously). Storage contents need no reset.

Decomposition:
- Shared package front_end_pkg holds:
  - NOP_INSTR.
  - IW and PCW defaults.
  - Opcode constants (ADD 0000, ADI 0001, NAND 0010, LHI 0011, LW 0100, SW 0101, BEQ 1100, JAL 1000, JLR 1001).
  - A fetch_entry typedef {instr, pc}.
- Natural sub-module: fdq_storage, a DEPTH x (IW+PCW) register array with 2 write ports and 2 async read ports.
- Pointer, count and flush logic stay in the top module.

Test Plan:
- Reset then idle: out_valid0/1=0, out_instr0=16'hF000, in_ready=1, occupancy=0.
- Push 2 (0x0291 @pc 0x10, 0x1283 @pc 0x11) with pop 0:
  - Next cycle out_instr0=0x0291/pc 0x10, out_instr1=0x1283/pc 0x11, occupancy=2.
- Fill to DEPTH=8 with push 2 and pop 0 for 4 cycles:
  - in_ready=0 at occupancy 8.
  - A further push 2 is dropped and occupancy stays 8.
  - Pop 1 takes occupancy to 7; in_ready stays 0.
  - Pop 1 again takes occupancy to 6; in_ready=1.
- Wrap-around:
  - Setup: push/pop streams so that tail=7 (DEPTH=8).
  - Stimulus: push 2 (pc 0x40, 0x41).
  - Required: entries land at indices 7 and 0, and a later pop 2 presents pc 0x40 then 0x41 in order.
- Occupancy 1 with pop_cnt=2 and push 2 in the same cycle:
  - eff_pop=1, occupancy becomes 2.
  - The outputs show the two new instructions in order.
- Flush with occupancy 5, push 2 and pop 1 in the same cycle:
  - Next cycle occupancy=0, out_valid0=0, in_ready=1.
  - The pushed instructions never appear.

Source files
------------

// File: rtl/front_end_pkg.sv
// Shared front-end definitions: bubble word, default widths, opcodes, fetch entry.
package front_end_pkg;

  localparam int unsigned IW_DEFAULT  = 16;
  localparam int unsigned PCW_DEFAULT = 16;

  // Opcode 1111 has no writeback and no memory access, so it serves as a bubble
  localparam logic [15:0] NOP_INSTR = 16'hF000;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JLR  = 4'b1001;

  typedef struct packed {
    logic [IW_DEFAULT-1:0]  instr;
    logic [PCW_DEFAULT-1:0] pc;
  } fetch_entry;

endpackage

// File: rtl/fdq_storage.sv
// Entry array for the fetch/decode queue: DEPTH x DW, two write ports, two async read ports.
//   we0/waddr0/wdata0, we1/waddr1/wdata1 : write ports (addresses never collide when both enabled)
//   raddr0/rdata0, raddr1/rdata1          : combinational read ports
module fdq_storage
  import front_end_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [PW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [PW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic [PW-1:0] raddr0,
  output logic [DW-1:0] rdata0,
  input  logic [PW-1:0] raddr1,
  output logic [DW-1:0] rdata1
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents need no reset; validity is tracked by the occupancy count
  always_ff @(posedge clk) begin
    if (we0) mem_q[waddr0] <= wdata0;
    if (we1) mem_q[waddr1] <= wdata1;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/fetch_decode_queue.sv
// Dual-issue instruction queue between fetch and the two decoders.
//   flush               : redirect, discards every entry (beats push/pop)
//   push_cnt, in_*      : 0-2 fetched instructions, in_instr0 older
//   in_ready            : room for two entries (registered state only)
//   pop_cnt             : entries retired by the decoders (clamped to occupancy)
//   out_valid/instr/pc  : two oldest entries in program order, NOP/0 when empty
//   occupancy           : current entry count
module fetch_decode_queue
  import front_end_pkg::*;
#(
  parameter int unsigned    DEPTH     = 8,
  parameter int unsigned    IW        = IW_DEFAULT,
  parameter int unsigned    PCW       = PCW_DEFAULT,
  parameter logic [IW-1:0]  NOP_INSTR = IW'(front_end_pkg::NOP_INSTR),
  localparam int unsigned   OCW       = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic [1:0]     push_cnt,
  input  logic [IW-1:0]  in_instr0,
  input  logic [PCW-1:0] in_pc0,
  input  logic [IW-1:0]  in_instr1,
  input  logic [PCW-1:0] in_pc1,
  output logic           in_ready,
  input  logic [1:0]     pop_cnt,
  output logic           out_valid0,
  output logic [IW-1:0]  out_instr0,
  output logic [PCW-1:0] out_pc0,
  output logic           out_valid1,
  output logic [IW-1:0]  out_instr1,
  output logic [PCW-1:0] out_pc1,
  output logic [OCW-1:0] occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = IW + PCW;

  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCW-1:0] occ_q, occ_d;
  logic [1:0]     push_req, pop_req, eff_push, eff_pop;
  logic           ready_c;
  logic           we0, we1;
  logic [PW-1:0]  waddr0, waddr1, raddr0, raddr1;
  logic [DW-1:0]  wdata0, wdata1, rdata0, rdata1;

  // Pointer / count next-state
  always_comb begin
    ready_c  = occ_q <= OCW'(DEPTH - 2);
    push_req = (push_cnt == 2'd3) ? 2'd2 : push_cnt;
    pop_req  = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
    eff_push = ready_c ? push_req : 2'd0;
    // Clamp only matters when occupancy is 0 or 1, so its low bits suffice
    eff_pop  = (OCW'(pop_req) > occ_q) ? occ_q[1:0] : pop_req;

    head_d = head_q + PW'(eff_pop);
    tail_d = tail_q + PW'(eff_push);
    occ_d  = occ_q + OCW'(eff_push) - OCW'(eff_pop);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end

    we0    = !flush && (eff_push != 2'd0);
    we1    = !flush && (eff_push == 2'd2);
    waddr0 = tail_q;
    waddr1 = tail_q + PW'(1);
    wdata0 = {in_instr0, in_pc0};
    wdata1 = {in_instr1, in_pc1};
    raddr0 = head_q;
    raddr1 = head_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  fdq_storage #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_storage (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .raddr0 (raddr0),
    .rdata0 (rdata0),
    .raddr1 (raddr1),
    .rdata1 (rdata1)
  );

  // Outputs derive from registered state only; invalid slots show a bubble
  always_comb begin
    in_ready   = ready_c;
    occupancy  = occ_q;
    out_valid0 = occ_q != '0;
    out_valid1 = occ_q >= OCW'(2);
    out_instr0 = out_valid0 ? rdata0[DW-1 -: IW] : NOP_INSTR;
    out_pc0    = out_valid0 ? rdata0[PCW-1:0]    : '0;
    out_instr1 = out_valid1 ? rdata1[DW-1 -: IW] : NOP_INSTR;
    out_pc1    = out_valid1 ? rdata1[PCW-1:0]    : '0;
  end

  a_push_cnt_legal: assert property (@(posedge clk) disable iff (!rst_n) push_cnt != 2'd3)
    else $error("push_cnt=3 is illegal");

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed vector table plus randomized
// traffic against a queue-based reference model.
module tb_fetch_decode_queue;
  import front_end_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  push_cnt, pop_cnt;
  logic [15:0] in_instr0, in_pc0, in_instr1, in_pc1;
  logic        in_ready, out_valid0, out_valid1;
  logic [15:0] out_instr0, out_pc0, out_instr1, out_pc1;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_cnt   (push_cnt),
    .in_instr0  (in_instr0),
    .in_pc0     (in_pc0),
    .in_instr1  (in_instr1),
    .in_pc1     (in_pc1),
    .in_ready   (in_ready),
    .pop_cnt    (pop_cnt),
    .out_valid0 (out_valid0),
    .out_instr0 (out_instr0),
    .out_pc0    (out_pc0),
    .out_valid1 (out_valid1),
    .out_instr1 (out_instr1),
    .out_pc1    (out_pc1),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of resident entries
  fetch_entry mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_update(input logic fl, input logic [1:0] pu, input logic [1:0] po,
                              input logic [15:0] i0, input logic [15:0] p0,
                              input logic [15:0] i1, input logic [15:0] p1);
    bit rdy;
    int n;
    fetch_entry e;
    rdy = (8 - mq.size()) >= 2;
    if (fl) begin
      mq.delete();
    end else begin
      n = (int'(po) < mq.size()) ? int'(po) : mq.size();
      repeat (n) void'(mq.pop_front());
      if (rdy && pu >= 2'd1) begin e.instr = i0; e.pc = p0; mq.push_back(e); end
      if (rdy && pu == 2'd2) begin e.instr = i1; e.pc = p1; mq.push_back(e); end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".occ"},    32'(occupancy),  32'(mq.size()));
    chk({tag, ".ready"},  32'(in_ready),   32'((8 - mq.size()) >= 2));
    chk({tag, ".v0"},     32'(out_valid0), 32'(mq.size() >= 1));
    chk({tag, ".v1"},     32'(out_valid1), 32'(mq.size() >= 2));
    chk({tag, ".instr0"}, 32'(out_instr0), 32'(mq.size() >= 1 ? mq[0].instr : NOP_INSTR));
    chk({tag, ".pc0"},    32'(out_pc0),    32'(mq.size() >= 1 ? mq[0].pc : 16'h0));
    chk({tag, ".instr1"}, 32'(out_instr1), 32'(mq.size() >= 2 ? mq[1].instr : NOP_INSTR));
    chk({tag, ".pc1"},    32'(out_pc1),    32'(mq.size() >= 2 ? mq[1].pc : 16'h0));
  endtask

  task automatic step(input logic fl, input logic [1:0] pu, input logic [1:0] po,
                      input logic [15:0] i0, input logic [15:0] p0,
                      input logic [15:0] i1, input logic [15:0] p1, input string tag);
    @(negedge clk);
    flush = fl; push_cnt = pu; pop_cnt = po;
    in_instr0 = i0; in_pc0 = p0; in_instr1 = i1; in_pc1 = p1;
    @(posedge clk);
    model_update(fl, pu, po, i0, p0, i1, p1);
    #1;
    model_check(tag);
  endtask

  typedef struct {
    logic        fl;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic [15:0] i0, p0, i1, p1;
    int          occ;
    logic        v0;
    logic [15:0] ins0, pc0;
    logic        v1;
    logic [15:0] pc1;
    logic        rdy;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic [1:0] pu, input logic [1:0] po,
                              input logic [15:0] p0, input int occ, input logic v0,
                              input logic [15:0] ins0, input logic [15:0] pc0,
                              input logic v1, input logic [15:0] pc1, input logic rdy);
    vec_t v;
    v.fl = fl; v.push = pu; v.pop = po;
    v.p0 = p0; v.p1 = p0 + 16'd1;
    v.i0 = 16'h4000 | v.p0; v.i1 = 16'h4000 | v.p1;
    v.occ = occ; v.v0 = v0; v.ins0 = ins0; v.pc0 = pc0; v.v1 = v1; v.pc1 = pc1; v.rdy = rdy;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    rst_n = 1'b0; flush = 1'b0; push_cnt = 2'd0; pop_cnt = 2'd0;
    in_instr0 = '0; in_pc0 = '0; in_instr1 = '0; in_pc1 = '0;

    //          fl push pop pc0    occ v0 ins0     pc0     v1 pc1     rdy
    tbl[0]  = mk(0, 2, 0, 16'h10, 2, 1, 16'h0291, 16'h10, 1, 16'h11, 1);
    tbl[0].i0 = 16'h0291; tbl[0].i1 = 16'h1283;
    tbl[1]  = mk(0, 2, 0, 16'h12, 4, 1, 16'h0291, 16'h10, 1, 16'h11, 1);
    tbl[2]  = mk(0, 2, 0, 16'h14, 6, 1, 16'h0291, 16'h10, 1, 16'h11, 1);
    tbl[3]  = mk(0, 2, 0, 16'h16, 8, 1, 16'h0291, 16'h10, 1, 16'h11, 0);
    tbl[4]  = mk(0, 2, 0, 16'h18, 8, 1, 16'h0291, 16'h10, 1, 16'h11, 0);  // dropped
    tbl[5]  = mk(0, 0, 1, 16'h00, 7, 1, 16'h1283, 16'h11, 1, 16'h12, 0);
    tbl[6]  = mk(0, 0, 1, 16'h00, 6, 1, 16'h4012, 16'h12, 1, 16'h13, 1);
    tbl[7]  = mk(0, 2, 0, 16'h18, 8, 1, 16'h4012, 16'h12, 1, 16'h13, 0);
    tbl[8]  = mk(0, 2, 2, 16'h1A, 6, 1, 16'h4014, 16'h14, 1, 16'h15, 1);  // full: push refused
    tbl[9]  = mk(0, 0, 1, 16'h00, 5, 1, 16'h4015, 16'h15, 1, 16'h16, 1);
    tbl[10] = mk(1, 2, 1, 16'h70, 0, 0, 16'hF000, 16'h00, 0, 16'h00, 1);  // flush
    tbl[11] = mk(0, 2, 0, 16'h30, 2, 1, 16'h4030, 16'h30, 1, 16'h31, 1);
    tbl[12] = mk(0, 2, 0, 16'h32, 4, 1, 16'h4030, 16'h30, 1, 16'h31, 1);
    tbl[13] = mk(0, 2, 0, 16'h34, 6, 1, 16'h4030, 16'h30, 1, 16'h31, 1);
    tbl[14] = mk(0, 1, 2, 16'h36, 5, 1, 16'h4032, 16'h32, 1, 16'h33, 1);  // tail -> 7
    tbl[15] = mk(0, 0, 2, 16'h00, 3, 1, 16'h4034, 16'h34, 1, 16'h35, 1);
    tbl[16] = mk(0, 0, 2, 16'h00, 1, 1, 16'h4036, 16'h36, 0, 16'h00, 1);
    tbl[17] = mk(0, 2, 2, 16'h40, 2, 1, 16'h4040, 16'h40, 1, 16'h41, 1);  // wrap 7->0, pop clamp
    tbl[18] = mk(0, 0, 2, 16'h00, 0, 0, 16'hF000, 16'h00, 0, 16'h00, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.occ",    32'(occupancy),  32'd0);
    chk("reset.ready",  32'(in_ready),   32'd1);
    chk("reset.v0",     32'(out_valid0), 32'd0);
    chk("reset.v1",     32'(out_valid1), 32'd0);
    chk("reset.instr0", 32'(out_instr0), 32'hF000);
    chk("reset.instr1", 32'(out_instr1), 32'hF000);
    chk("reset.pc0",    32'(out_pc0),    32'd0);

    // Directed table
    for (int k = 0; k < 19; k++) begin
      string t;
      t = $sformatf("vec%0d", k);
      step(tbl[k].fl, tbl[k].push, tbl[k].pop, tbl[k].i0, tbl[k].p0, tbl[k].i1, tbl[k].p1, t);
      chk({t, ".t_occ"},    32'(occupancy),  32'(tbl[k].occ));
      chk({t, ".t_v0"},     32'(out_valid0), 32'(tbl[k].v0));
      chk({t, ".t_instr0"}, 32'(out_instr0), 32'(tbl[k].ins0));
      chk({t, ".t_pc0"},    32'(out_pc0),    32'(tbl[k].pc0));
      chk({t, ".t_v1"},     32'(out_valid1), 32'(tbl[k].v1));
      chk({t, ".t_pc1"},    32'(out_pc1),    32'(tbl[k].pc1));
      chk({t, ".t_ready"},  32'(in_ready),   32'(tbl[k].rdy));
    end

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      logic [15:0] pc;
      pc = 16'($urandom);
      step(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
           16'($urandom), pc, 16'($urandom), pc + 16'd1, $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a cycle
    step(0, 2, 0, 16'h4050, 16'h50, 16'h4051, 16'h51, "pre_arst0");
    step(0, 2, 0, 16'h4052, 16'h52, 16'h4053, 16'h53, "pre_arst1");
    @(negedge clk);
    flush = 1'b0; push_cnt = 2'd0; pop_cnt = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.occ",    32'(occupancy),  32'd0);
    chk("arst.v0",     32'(out_valid0), 32'd0);
    chk("arst.ready",  32'(in_ready),   32'd1);
    chk("arst.instr0", 32'(out_instr0), 32'hF000);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] pc;
      pc = 16'($urandom);
      step(1'b0, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)),
           16'($urandom), pc, 16'($urandom), pc + 16'd1, $sformatf("post%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
